// File: rtl/door_ctrl_pkg.sv
// Shared encodings for the door controller: game-state values and door FSM states.
package door_ctrl_pkg;

  typedef enum logic [3:0] {
    GS_TITLE    = 4'd0,
    GS_STAFF    = 4'd1,
    GS_STAGE1   = 4'd2,
    GS_SUCCESS1 = 4'd3,
    GS_STAGE2   = 4'd4,
    GS_SUCCESS2 = 4'd5,
    GS_STAGE3   = 4'd6,
    GS_SUCCESS3 = 4'd7,
    GS_FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [2:0] {
    DOOR_IDLE      = 3'd0,
    DOOR_LOCKED    = 3'd1,
    DOOR_UNLOCKING = 3'd2,
    DOOR_OPEN      = 3'd3,
    DOOR_DONE      = 3'd4
  } door_state_e;

  function automatic logic is_play_stage(input logic [3:0] s);
    return (s == GS_STAGE1) || (s == GS_STAGE2) || (s == GS_STAGE3);
  endfunction

endpackage

// File: rtl/door_anim_timer.sv
// Unlock animation pacing: counts frame ticks per step and steps per sequence.
module door_anim_timer #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned NUM_STEPS       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       frame_tick,
  output logic [1:0] step,
  output logic       done
);

  localparam int unsigned FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]     step_q, step_d;
  logic           last_frame, last_step;

  always_comb begin
    last_frame  = (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1));
    last_step   = (step_q == 2'(NUM_STEPS - 1));
    frame_cnt_d = frame_cnt_q;
    step_d      = step_q;
    done        = 1'b0;
    if (clr) begin
      frame_cnt_d = '0;
      step_d      = '0;
    end else if (en && frame_tick) begin
      if (last_frame) begin
        frame_cnt_d = '0;
        // Wrap to zero on completion so the next unlock starts clean
        if (last_step) begin
          step_d = '0;
          done   = 1'b1;
        end else begin
          step_d = step_q + 2'd1;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      step_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/door_ctrl.sv
// Door sprite sequencer: lock/key tracking, frame-paced unlock animation, exit pulse.
// Optional deny blink indicator enabled by defining DOOR_DENY_BLINK_EN.
module door_ctrl
  import door_ctrl_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned NUM_STEPS       = 4,
  parameter int unsigned DENY_FRAMES     = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic       key_get,
  input  logic       at_door,
  input  logic       use_btn,
  output logic       isLocked,
  output logic [1:0] door_frame,
  output logic       door_open,
  output logic       stage_done,
  output logic       deny_flash
);

  if (NUM_STEPS == 0 || NUM_STEPS > 4 || FRAMES_PER_STEP == 0 || DENY_FRAMES == 0) begin : g_bad_cfg
    $error("door_ctrl: invalid parameter set");
  end

  door_state_e fsm_q, fsm_d;
  logic [3:0]  prev_state_q;
  logic        has_key_q, has_key_d;
  logic        stage_done_q, stage_done_d;
  logic        stage_chg, at_use;
  logic        tmr_done;
  logic [1:0]  tmr_step;

  assign stage_chg = (state != prev_state_q);
  assign at_use    = use_btn & at_door;

  door_anim_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP),
    .NUM_STEPS      (NUM_STEPS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (stage_chg),
    .en        (fsm_q == DOOR_UNLOCKING),
    .frame_tick(frame_tick),
    .step      (tmr_step),
    .done      (tmr_done)
  );

  always_comb begin
    fsm_d        = fsm_q;
    has_key_d    = has_key_q;
    stage_done_d = 1'b0;
    if (stage_chg) begin
      has_key_d = 1'b0;
      fsm_d     = is_play_stage(state) ? DOOR_LOCKED : DOOR_IDLE;
    end else begin
      case (fsm_q)
        DOOR_LOCKED: begin
          if (key_get) has_key_d = 1'b1;
          // Registered has_key is used, so a same-cycle pickup still denies
          if (at_use && has_key_q) begin
            fsm_d     = DOOR_UNLOCKING;
            has_key_d = 1'b0;
          end
        end
        DOOR_UNLOCKING: if (tmr_done) fsm_d = DOOR_OPEN;
        DOOR_OPEN: begin
          if (at_use) begin
            stage_done_d = 1'b1;
            fsm_d        = DOOR_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q        <= DOOR_IDLE;
      prev_state_q <= '0;
      has_key_q    <= 1'b0;
      stage_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= state;
      has_key_q    <= has_key_d;
      stage_done_q <= stage_done_d;
    end
  end

  always_comb begin
    isLocked   = 1'b1;
    door_open  = 1'b0;
    door_frame = '0;
    case (fsm_q)
      DOOR_UNLOCKING: door_frame = tmr_step;
      DOOR_OPEN, DOOR_DONE: begin
        isLocked   = 1'b0;
        door_open  = 1'b1;
        door_frame = 2'(NUM_STEPS - 1);
      end
      default: ;
    endcase
  end

  assign stage_done = stage_done_q;

`ifdef DOOR_DENY_BLINK_EN
  localparam int unsigned DCW = ($clog2(DENY_FRAMES + 1) > 3) ? $clog2(DENY_FRAMES + 1) : 3;

  logic [DCW-1:0] deny_cnt_q, deny_cnt_d;
  logic           deny_evt;

  assign deny_evt = !stage_chg && (fsm_q == DOOR_LOCKED) && at_use && !has_key_q;

  always_comb begin
    deny_cnt_d = deny_cnt_q;
    if (stage_chg)                           deny_cnt_d = '0;
    else if (deny_evt)                       deny_cnt_d = DCW'(DENY_FRAMES);
    else if (frame_tick && deny_cnt_q != '0) deny_cnt_d = deny_cnt_q - DCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) deny_cnt_q <= '0;
    else        deny_cnt_q <= deny_cnt_d;
  end

  assign deny_flash = (deny_cnt_q != '0) & deny_cnt_q[2];
`else
  assign deny_flash = 1'b0;
`endif

endmodule

// File: tb/tb_door_ctrl.sv
// Scoreboard bench for door_ctrl: directed stimulus queues expectations, negedge monitor checks.
module tb_door_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic       frame_tick, key_get, at_door, use_btn;
  logic       isLocked;
  logic [1:0] door_frame;
  logic       door_open, stage_done, deny_flash;

`ifdef DOOR_DENY_BLINK_EN
  localparam bit DENY_EN = 1'b1;
`else
  localparam bit DENY_EN = 1'b0;
`endif

  typedef struct {
    int         due;
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  door_ctrl #(
    .FRAMES_PER_STEP(8),
    .NUM_STEPS      (4),
    .DENY_FRAMES    (30)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .frame_tick(frame_tick),
    .key_get   (key_get),
    .at_door   (at_door),
    .use_btn   (use_btn),
    .isLocked  (isLocked),
    .door_frame(door_frame),
    .door_open (door_open),
    .stage_done(stage_done),
    .deny_flash(deny_flash)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs after the most recent clock edge; {lk, frame, open, done, flash}
  task automatic expect_out(input string name, input logic lk, input logic [1:0] fr,
                            input logic op, input logic sd, input logic flv);
    exp_t e;
    e.due  = cyc;
    e.name = name;
    e.exp  = {lk, fr, op, sd, DENY_EN & flv};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [5:0] act;
    exp_t       e;
    act = {isLocked, door_frame, door_open, stage_done, deny_flash};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.due != cyc || act !== e.exp) begin
        bad++;
        $display("FAIL %s: got=%b want=%b (due %0d, seen %0d)", e.name, act, e.exp, e.due, cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; state = 4'd0; frame_tick = 1'b0;
    key_get = 1'b0; at_door = 1'b0; use_btn = 1'b0;
    repeat (3) step();
    expect_out("reset", 1, 2'd0, 0, 0, 0);

    rst_n = 1'b1; state = 4'd2; step();
    expect_out("stage1_lock", 1, 2'd0, 0, 0, 0);

    at_door = 1'b1; use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("deny_nokey", 1, 2'd0, 0, 0, 1);

    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 3)  expect_out("deny_blink_off", 1, 2'd0, 0, 0, 0);
      if (i == 7)  expect_out("deny_blink_on",  1, 2'd0, 0, 0, 1);
      if (i == 30) expect_out("deny_expired",   1, 2'd0, 0, 0, 0);
      step();
    end

    key_get = 1'b1; step(); key_get = 1'b0;
    expect_out("key_taken", 1, 2'd0, 0, 0, 0);
    use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("unlock_start", 1, 2'd0, 0, 0, 0);

    for (int k = 1; k <= 32; k++) begin
      tick();
      case (k)
        7:  expect_out("anim_t7",  1, 2'd0, 0, 0, 0);
        8:  expect_out("anim_t8",  1, 2'd1, 0, 0, 0);
        16: expect_out("anim_t16", 1, 2'd2, 0, 0, 0);
        24: expect_out("anim_t24", 1, 2'd3, 0, 0, 0);
        31: expect_out("anim_t31", 1, 2'd3, 0, 0, 0);
        32: expect_out("anim_open", 0, 2'd3, 1, 0, 0);
        default: ;
      endcase
      step();
    end

    use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("exit_pulse", 0, 2'd3, 1, 1, 0);
    step();
    expect_out("exit_clear", 0, 2'd3, 1, 0, 0);
    use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("done_no_repulse", 0, 2'd3, 1, 0, 0);

    state = 4'd3; step();
    expect_out("success_idle", 1, 2'd0, 0, 0, 0);
    key_get = 1'b1; use_btn = 1'b1; step(); key_get = 1'b0; use_btn = 1'b0;
    expect_out("idle_ignores", 1, 2'd0, 0, 0, 0);

    state = 4'd4; step();
    expect_out("stage2_lock", 1, 2'd0, 0, 0, 0);
    key_get = 1'b1; use_btn = 1'b1; step(); key_get = 1'b0; use_btn = 1'b0;
    expect_out("same_cycle_deny", 1, 2'd0, 0, 0, 1);
    step();
    expect_out("deny_hold", 1, 2'd0, 0, 0, 1);
    use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("second_use_unlock", 1, 2'd0, 0, 0, 1);

    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4)  expect_out("b_t4",  1, 2'd0, 0, 0, 0);
      if (k == 8)  expect_out("b_t8",  1, 2'd1, 0, 0, 1);
      if (k == 12) expect_out("b_t12", 1, 2'd1, 0, 0, 0);
      step();
    end

    state = 4'd8; step();
    expect_out("fail_idle", 1, 2'd0, 0, 0, 0);
    state = 4'd4; step();
    expect_out("restage_lock", 1, 2'd0, 0, 0, 0);
    key_get = 1'b1; step(); key_get = 1'b0;
    use_btn = 1'b1; step(); use_btn = 1'b0;
    expect_out("c_start", 1, 2'd0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) expect_out("c_t7", 1, 2'd0, 0, 0, 0);
      if (k == 8) expect_out("c_t8", 1, 2'd1, 0, 0, 0);
      step();
    end

    rst_n = 1'b0; step();
    expect_out("rst_mid_anim", 1, 2'd0, 0, 0, 0);
    rst_n = 1'b1; step();
    expect_out("post_rst_lock", 1, 2'd0, 0, 0, 0);
    key_get = 1'b1; step(); key_get = 1'b0;
    use_btn = 1'b1; step(); use_btn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) expect_out("d_t7", 1, 2'd0, 0, 0, 0);
      if (k == 8) expect_out("d_t8", 1, 2'd1, 0, 0, 0);
      step();
    end

    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
